// File: rtl/fft_stage_sequencer.sv
// Stage/pair sequencer for an in-place radix-2 FFT: issues (stage, pair_id) to the AGU,
// drains between stages, and delays the AGU addresses to line up with butterfly writeback.
module fft_stage_sequencer #(
  parameter int N          = 1024,
  parameter int MEM_RD_LAT = 1,
  parameter int BFLY_LAT   = 4,
  localparam int LOG2N     = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic [LOG2N-2:0] pair_id,
  output logic             issue_valid,
  input  logic [LOG2N-1:0] addr1_in,
  input  logic [LOG2N-1:0] addr2_in,
  output logic             rd_en,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr1,
  output logic [LOG2N-1:0] wr_addr2
);

  localparam int PW = LOG2N - 1;
  localparam int T  = 1 + MEM_RD_LAT + BFLY_LAT;
  localparam int DL = MEM_RD_LAT + BFLY_LAT;  // always >= 2
  localparam int CW = $clog2(T);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pair_nxt;
  logic [LOG2N-1:0] stage_nxt;
  logic [CW-1:0]   drain_cnt, drain_nxt;
  logic            last_stage;

  assign last_stage  = (stage == LOG2N'(LOG2N - 1));
  assign issue_valid = (state == RUN);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stage     <= '0;
      pair_id   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stage     <= stage_nxt;
      pair_id   <= pair_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    pair_nxt  = pair_id;
    drain_nxt = drain_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          stage_nxt = '0;
          pair_nxt  = '0;
        end
      end
      RUN: begin
        if (pair_id == PW'(N / 2 - 1)) begin
          // pair_id parks on the last pair through the drain instead of wrapping
          state_nxt = DRAIN;
          drain_nxt = last_stage ? CW'(T - 1) : CW'(T - 2);
        end else begin
          pair_nxt = pair_id + PW'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          if (last_stage) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            stage_nxt = stage + LOG2N'(1);
            pair_nxt  = '0;
          end
        end else begin
          drain_nxt = drain_cnt - CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        stage_nxt = '0;
        pair_nxt  = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address delay line: DL-1 shift stages plus the output register make DL cycles
  // from rd_en, i.e. T cycles from issue to wr_en.
  logic [DL-2:0]        dl_valid;
  logic [2*LOG2N-1:0]   dl_addr [DL-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en    <= 1'b0;
      dl_valid <= '0;
      wr_en    <= 1'b0;
      wr_addr1 <= '0;
      wr_addr2 <= '0;
    end else begin
      rd_en       <= issue_valid;
      dl_valid[0] <= rd_en;
      for (int i = 1; i < DL - 1; i++) dl_valid[i] <= dl_valid[i-1];
      wr_en <= dl_valid[DL-2];
      if (dl_valid[DL-2]) begin
        {wr_addr1, wr_addr2} <= dl_addr[DL-2];
      end
    end
  end

  // NOTE: the address payload is not reset; only its valid bits are, which is enough
  // to keep stale addresses from ever reaching the write port.
  always_ff @(posedge clk) begin
    if (rd_en) dl_addr[0] <= {addr1_in, addr2_in};
    for (int i = 1; i < DL - 1; i++) dl_addr[i] <= dl_addr[i-1];
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer at N=8 (T=6) plus a MEM_RD_LAT=2/BFLY_LAT=1 hazard sweep.
module tb_fft_stage_sequencer;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int PW    = LOG2N - 1;
  localparam int NH    = N / 2;
  localparam int T     = 6;
  localparam int PER   = NH + T - 1;                              // issue period of one stage
  localparam int LAST  = LOG2N * NH + (LOG2N - 1) * (T - 1) + T;  // done cycle offset (28)

  logic clk, reset, start, start_b;
  logic busy, done, issue_valid, rd_en, wr_en;
  logic [LOG2N-1:0] stage, addr1_in, addr2_in, wr_addr1, wr_addr2;
  logic [PW-1:0] pair_id;
  logic busy_b, done_b, issue_valid_b, rd_en_b, wr_en_b;
  logic [LOG2N-1:0] stage_b, addr1_in_b, addr2_in_b, wr_addr1_b, wr_addr2_b;
  logic [PW-1:0] pair_id_b;

  int checks = 0;
  int errors = 0;
  bit chained = 0;

  typedef struct {
    int               cyc;
    logic [LOG2N-1:0] a1;
    logic [LOG2N-1:0] a2;
  } wr_t;
  wr_t sb[$];

  fft_stage_sequencer #(.N(N), .MEM_RD_LAT(1), .BFLY_LAT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .stage(stage), .pair_id(pair_id), .issue_valid(issue_valid),
    .addr1_in(addr1_in), .addr2_in(addr2_in), .rd_en(rd_en), .wr_en(wr_en),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2)
  );

  fft_stage_sequencer #(.N(N), .MEM_RD_LAT(2), .BFLY_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .stage(stage_b), .pair_id(pair_id_b), .issue_valid(issue_valid_b),
    .addr1_in(addr1_in_b), .addr2_in(addr2_in_b), .rd_en(rd_en_b), .wr_en(wr_en_b),
    .wr_addr1(wr_addr1_b), .wr_addr2(wr_addr2_b)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // AGU model: pair index rotated right by the stage, partner N/2 above.
  function automatic logic [LOG2N-1:0] agu_a1(input int s, input int p);
    int sh;
    int r;
    sh = s % PW;
    r  = ((p >> sh) | (p << (PW - sh))) & (NH - 1);
    return LOG2N'(r);
  endfunction

  always @(posedge clk) begin
    addr1_in   <= agu_a1(int'(stage), int'(pair_id));
    addr2_in   <= agu_a1(int'(stage), int'(pair_id)) | LOG2N'(NH);
    addr1_in_b <= agu_a1(int'(stage_b), int'(pair_id_b));
    addr2_in_b <= agu_a1(int'(stage_b), int'(pair_id_b)) | LOG2N'(NH);
  end

  function automatic bit exp_issue(input int i);
    return (i >= 0) && (i < LOG2N * PER) && ((i % PER) < NH);
  endfunction

  task automatic test_reset();
    reset = 1;
    start = 0;
    start_b = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, issue_valid, rd_en, wr_en, stage, pair_id, wr_addr1, wr_addr2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b iv=%b rd=%b wr=%b stage=%0d pair=%0d wa1=%0d wa2=%0d, want all 0",
               busy, done, issue_valid, rd_en, wr_en, stage, pair_id, wr_addr1, wr_addr2);
    end
    reset = 0;
  endtask

  // One full run checked cycle by cycle against the expected schedule and write scoreboard.
  task automatic run_check(input string tag, input bit noise, input bit chain);
    int wr_seen = 0, rd_cnt = 0, last_wr0 = -1, first_rd1 = -1;
    bit eiss;
    logic [LOG2N-1:0] es, a1;
    logic [PW-1:0] ep;
    wr_t e;
    sb.delete();
    for (int s = 0; s < LOG2N; s++)
      for (int p = 0; p < NH; p++) begin
        a1 = agu_a1(s, p);
        sb.push_back('{s * PER + p + T, a1, a1 | LOG2N'(NH)});
      end
    if (!chained) begin
      @(negedge clk);
      start = 1;
    end
    chained = 0;
    for (int i = 0; i <= LAST + 3; i++) begin
      @(negedge clk);
      eiss = exp_issue(i);
      es = LOG2N'(i / PER);
      ep = PW'(i % PER);
      checks++;
      if (issue_valid !== eiss) begin
        errors++;
        $display("FAIL %s issue_valid c%0d: got %b want %b", tag, i, issue_valid, eiss);
      end
      if (eiss) begin
        checks++;
        if (stage !== es || pair_id !== ep) begin
          errors++;
          $display("FAIL %s issue_idx c%0d: got stage=%0d pair=%0d want stage=%0d pair=%0d",
                   tag, i, stage, pair_id, es, ep);
        end
      end
      checks++;
      if (rd_en !== exp_issue(i - 1)) begin
        errors++;
        $display("FAIL %s rd_en c%0d: got %b want %b", tag, i, rd_en, exp_issue(i - 1));
      end
      checks++;
      if (busy !== (i < LAST) || done !== (i == LAST)) begin
        errors++;
        $display("FAIL %s busy_done c%0d: got busy=%b done=%b want busy=%b done=%b",
                 tag, i, busy, done, (i < LAST), (i == LAST));
      end
      if (i > LAST) begin
        checks++;
        if (stage !== '0 || pair_id !== '0) begin
          errors++;
          $display("FAIL %s idle_counters c%0d: got stage=%0d pair=%0d want 0 0", tag, i, stage, pair_id);
        end
      end
      if (wr_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_wr c%0d: got wr_en=1 want no more writes", tag, i);
        end else begin
          e = sb.pop_front();
          if (i !== e.cyc || wr_addr1 !== e.a1 || wr_addr2 !== e.a2) begin
            errors++;
            $display("FAIL %s wr c%0d: got c%0d (%0d,%0d) want c%0d (%0d,%0d)",
                     tag, wr_seen, i, wr_addr1, wr_addr2, e.cyc, e.a1, e.a2);
          end
        end
        if (wr_seen == NH + 2) begin
          checks++;
          if (wr_addr1 !== 3'd1 || wr_addr2 !== 3'd5) begin
            errors++;
            $display("FAIL %s s1p2_pair: got (%0d,%0d) want (1,5)", tag, wr_addr1, wr_addr2);
          end
        end
        wr_seen++;
        if (wr_seen == NH) last_wr0 = i;
      end
      if (rd_en) begin
        rd_cnt++;
        if (rd_cnt == NH + 1) first_rd1 = i;
      end
      start = (noise && (i == 5 || i == LAST));
      if (chain && i == LAST + 1) begin
        start = 1;
        chained = 1;
        break;
      end
    end
    checks++;
    if (wr_seen != LOG2N * NH || sb.size() != 0) begin
      errors++;
      $display("FAIL %s wr_count: got %0d writes, %0d missing, want %0d", tag, wr_seen, sb.size(), LOG2N * NH);
    end
    checks++;
    if (last_wr0 != NH + T - 1 || first_rd1 != NH + T || first_rd1 <= last_wr0) begin
      errors++;
      $display("FAIL %s hazard: got last_wr0=c%0d first_rd1=c%0d want c%0d c%0d",
               tag, last_wr0, first_rd1, NH + T - 1, NH + T);
    end
  endtask

  task automatic test_nominal();
    run_check("nominal", 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_check("start_ignored", 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      start = 0;
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({busy, done, issue_valid, rd_en, wr_en, stage, pair_id, wr_addr1, wr_addr2} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run_outputs: got busy=%b done=%b iv=%b rd=%b wr=%b stage=%0d pair=%0d wa1=%0d wa2=%0d, want all 0",
               busy, done, issue_valid, rd_en, wr_en, stage, pair_id, wr_addr1, wr_addr2);
    end
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_run_flush +%0d: got wr_en=%b busy=%b iv=%b want 0 0 0", i, wr_en, busy, issue_valid);
      end
    end
    run_check("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_check("b2b_first", 1'b0, 1'b1);
    run_check("b2b_second", 1'b0, 1'b0);
  endtask

  // MEM_RD_LAT=2, BFLY_LAT=1: T=4, stage period 7, done at offset 22.
  task automatic test_hazard_sweep();
    int wr_cnt = 0, rd_cnt = 0, last_wr0 = -1, first_rd1 = -1, done_at = -1;
    @(negedge clk);
    start_b = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start_b = 0;
      if (wr_en_b) begin
        wr_cnt++;
        if (wr_cnt == NH) last_wr0 = i;
      end
      if (rd_en_b) begin
        rd_cnt++;
        if (rd_cnt == NH + 1) first_rd1 = i;
      end
      if (done_b) begin
        done_at = i;
        break;
      end
    end
    checks++;
    if (last_wr0 != 7 || first_rd1 != 8 || first_rd1 <= last_wr0) begin
      errors++;
      $display("FAIL sweep_hazard: got last_wr0=c%0d first_rd1=c%0d want c7 c8", last_wr0, first_rd1);
    end
    checks++;
    if (wr_cnt != LOG2N * NH || done_at != 22) begin
      errors++;
      $display("FAIL sweep_run: got %0d writes done at c%0d want %0d writes done at c22",
               wr_cnt, done_at, LOG2N * NH);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    start = 0;
    start_b = 0;
    test_reset();
    test_nominal();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_hazard_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
